// File: rtl/delay_line_prog.sv
// delay_line_prog: runtime-programmable multi-channel delay line.
// CH channels of N bits plus a valid flag are delayed by 0..MAX_DELAY
// clock-enable strobes through a shared circular buffer.
// Optional build macro: DELAY_LINE_PROG_GATE_EN forces odata to zero while
// ovalid is low (or while ivalid is low in zero-delay pass-through).
module delay_line_prog #(
  parameter int N         = 8,
  parameter int CH        = 3,
  parameter int MAX_DELAY = 16,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DW-1:0]     delay_sel,
  input  logic [CH*N-1:0]   idata,
  input  logic              ivalid,
  output logic [CH*N-1:0]   odata,
  output logic              ovalid,
  output logic              primed,
  output logic [DW-1:0]     cur_delay
);

  localparam int W  = CH * N + 1;
  localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);
  localparam logic [PW-1:0] LAST  = PW'(MAX_DELAY - 1);

  logic [W-1:0]  mem_q [MAX_DELAY];
  logic [W-1:0]  mem_d [MAX_DELAY];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [DW-1:0] fill_q, fill_d;
  logic [DW-1:0] wptr_w;
  logic [PW-1:0] tap_idx;
  logic [W-1:0]  tap;

  // Next state: write the sample, advance the pointer, reload the clamped delay, count fill.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    dly_d  = dly_q;
    fill_d = fill_q;
    if (ce) begin
      mem_d[wptr_q] = {ivalid, idata};
      wptr_d        = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
      dly_d         = (delay_sel > MAX_D) ? MAX_D : delay_sel;
      if (fill_q < MAX_D) fill_d = fill_q + 1'b1;
    end
  end

  // State registers; reset clears the whole buffer so stale data never leaks across reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_DELAY; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      dly_q  <= '0;
      fill_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      dly_q  <= dly_d;
      fill_q <= fill_d;
    end
  end

  // Tap index (wptr - D) mod MAX_DELAY with an explicit wrap so any depth works.
  always_comb begin
    wptr_w = DW'(wptr_q);
    if (wptr_w >= dly_q) tap_idx = PW'(wptr_w - dly_q);
    else                 tap_idx = PW'(wptr_w + (MAX_D - dly_q));
  end

  // Output stage: combinational from registers; D=0 bypasses the buffer entirely.
  always_comb begin
    tap       = mem_q[tap_idx];
    cur_delay = dly_q;
    if (dly_q == '0) begin
      primed = 1'b1;
      ovalid = ivalid;
`ifdef DELAY_LINE_PROG_GATE_EN
      odata  = ivalid ? idata : '0;
`else
      odata  = idata;
`endif
    end else begin
      primed = (fill_q >= dly_q);
      ovalid = tap[W-1] & primed;
`ifdef DELAY_LINE_PROG_GATE_EN
      odata  = ovalid ? tap[W-2:0] : '0;
`else
      odata  = tap[W-2:0];
`endif
    end
  end

endmodule

// File: tb/tb_delay_line_prog.sv
// Testbench for delay_line_prog: directed and randomized stimulus checked
// against a history-queue reference model.
module tb_delay_line_prog;

  localparam int N = 8, CH = 3, M = 16, DW = 5;
  localparam int DWID = CH * N;
  localparam int OW = DW + 2 + DWID;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ce = 1'b0;
  logic [DW-1:0]   delay_sel = '0;
  logic [DWID-1:0] idata = '0;
  logic            ivalid = 1'b0;
  logic [DWID-1:0] odata;
  logic            ovalid, primed;
  logic [DW-1:0]   cur_delay;

  int checks = 0;
  int failures = 0;

  // Model: every sample written since reset, in order, plus the delay in effect.
  logic [DWID:0] hist [$];
  int            d_m = 0;

  logic [OW-1:0] act, exp_v;

  delay_line_prog #(.N(N), .CH(CH), .MAX_DELAY(M), .DW(DW)) dut (
    .clk(clk), .rst(rst), .ce(ce), .delay_sel(delay_sel),
    .idata(idata), .ivalid(ivalid), .odata(odata), .ovalid(ovalid),
    .primed(primed), .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  assign act = {cur_delay, primed, ovalid, odata};

  function automatic int clamp_sel(input logic [DW-1:0] s);
    return (int'(s) > M) ? M : int'(s);
  endfunction

  // Expected outputs: the sample written d_m strobes ago, primed once enough have been written.
  function automatic logic [OW-1:0] model_out();
    logic          pr, ov;
    logic [DWID:0] t;
    logic [DWID-1:0] od;
    int nw, fl;
    if (d_m == 0) begin
      pr = 1'b1;
      ov = ivalid;
`ifdef DELAY_LINE_PROG_GATE_EN
      od = ivalid ? idata : '0;
`else
      od = idata;
`endif
    end else begin
      nw = hist.size();
      fl = (nw < M) ? nw : M;
      pr = (fl >= d_m);
      t  = (nw >= d_m) ? hist[nw - d_m] : '0;
      ov = t[DWID] & pr;
`ifdef DELAY_LINE_PROG_GATE_EN
      od = ov ? t[DWID-1:0] : '0;
`else
      od = t[DWID-1:0];
`endif
    end
    return {DW'(d_m), pr, ov, od};
  endfunction

  task automatic cycle(input logic c, input logic [DW-1:0] s,
                       input logic [DWID-1:0] d, input logic v);
    @(negedge clk);
    ce = c; delay_sel = s; idata = d; ivalid = v;
    @(posedge clk);
    if (c) begin
      hist.push_back({v, d});
      d_m = clamp_sel(s);
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    ce = 1'b0;
    rst = 1'b1;
    #2;
    hist.delete();
    d_m = 0;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; ce = 1'b1; idata = 24'hABCDEF; ivalid = 1'b1; delay_sel = 5'd7;
    hist.delete(); d_m = 0;
    #2;
    exp_v = model_out();
    checks++;
    if (act !== exp_v) begin failures++; $display("FAIL reset_state: got %h expected %h", act, exp_v); end
    ivalid = 1'b0; idata = 24'h123456;
    #1;
    exp_v = model_out();
    checks++;
    if (act !== exp_v) begin failures++; $display("FAIL reset_passthru: got %h expected %h", act, exp_v); end
    ce = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  task automatic test_ramp_delay5();
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      cycle(1'b1, 5'd5, DWID'(k), 1'b1);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL ramp_d5 k=%0d: got %h expected %h", k, act, exp_v); end
      if (k >= 5) begin
        checks++;
        if (odata !== DWID'(k - 4) || primed !== 1'b1) begin
          failures++; $display("FAIL ramp_d5_lag k=%0d: got odata %h primed %b expected %h 1", k, odata, primed, k - 4);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(1'(k % 2), 5'd0, 24'($urandom), 1'($urandom));
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL passthru_edge k=%0d: got %h expected %h", k, act, exp_v); end
      idata = 24'($urandom); ivalid = ~ivalid;
      #1;
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL passthru_comb k=%0d: got %h expected %h", k, act, exp_v); end
    end
  endtask

  task automatic test_max_wrap();
    do_reset();
    for (int k = 1; k <= 40; k++) begin
      cycle(1'b1, 5'd16, DWID'(k * 3 + 1), 1'b1);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL max_wrap k=%0d: got %h expected %h", k, act, exp_v); end
    end
  endtask

  task automatic test_delay_change();
    do_reset();
    for (int k = 1; k <= 34; k++) begin
      cycle(1'b1, (k <= 20) ? 5'd3 : 5'd12, 24'($urandom), 1'b1);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL dly_change k=%0d: got %h expected %h", k, act, exp_v); end
    end
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      cycle(1'b1, (k <= 4) ? 5'd3 : 5'd12, 24'($urandom), 1'b1);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL dly_raise k=%0d: got %h expected %h", k, act, exp_v); end
      if (k >= 5 && k < 12) begin
        checks++;
        if (primed !== 1'b0) begin failures++; $display("FAIL dly_raise_primed k=%0d: got %b expected 0", k, primed); end
      end
    end
  endtask

  task automatic test_clamp();
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      cycle(1'b1, 5'd31, 24'($urandom), 1'($urandom));
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL clamp k=%0d: got %h expected %h", k, act, exp_v); end
    end
    checks++;
    if (cur_delay !== 5'd16) begin failures++; $display("FAIL clamp_cur: got %0d expected 16", cur_delay); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int k = 0; k < 14; k++) begin
      cycle(1'(~k[0]), 5'd4, 24'($urandom), 1'b1);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL mid_pre k=%0d: got %h expected %h", k, act, exp_v); end
    end
    rst = 1'b1;
    #2;
    hist.delete(); d_m = 0;
    exp_v = model_out();
    checks++;
    if (act !== exp_v) begin failures++; $display("FAIL mid_rst: got %h expected %h", act, exp_v); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycle(1'(~k[0]), 5'd4, 24'($urandom), 1'b1);
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL mid_post k=%0d: got %h expected %h", k, act, exp_v); end
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] s;
    do_reset();
    s = 5'd0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 15) == 0) s = 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 3) != 0), s, 24'($urandom), 1'($urandom));
      exp_v = model_out();
      checks++;
      if (act !== exp_v) begin failures++; $display("FAIL random k=%0d: got %h expected %h", k, act, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_delay5();
    test_passthrough();
    test_max_wrap();
    test_delay_change();
    test_clamp();
    test_reset_midstream();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_line_prog.md
# delay_line_prog

Runtime-programmable, multi-channel delay line for the video pipeline. It aligns CH parallel N-bit channels, such as the R/G/B components of a pixel, plus a data-valid flag, to other pipeline branches. The delay is 0..MAX_DELAY clock-enable strobes and is selectable at run time. It replaces fixed-depth register chains where the required alignment depends on the selected filter mode (median window size, bypass).

## Interface
Parameters:
- N, 8, bit width of one channel
- CH, 3, number of channels; data buses are CH*N bits, channel k at bits [k*N+N-1 : k*N]
- MAX_DELAY, 16, buffer depth in samples (≥1, need not be a power of two)
- DW, $clog2(MAX_DELAY+1), width of delay_sel

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ce  in  1  clock enable; one sample is accepted per clk edge with ce=1
- delay_sel  in  DW  requested delay in ce strobes
- idata  in  CH*N  input sample, all channels
- ivalid  in  1  input data-valid flag, travels with idata
- odata  out  CH*N  delayed sample
- ovalid  out  1  delayed valid flag, qualified by primed
- primed  out  1  at least D samples written since reset
- cur_delay  out  DW  delay currently in effect (D)

## Operation
- Storage: circular array of MAX_DELAY entries, each CH*N+1 bits wide (data plus valid bit).
- wptr points to the next slot to write. On each ce edge:
  - mem[wptr] ← {ivalid, idata}.
  - wptr ← (wptr+1), wrapping from MAX_DELAY-1 to 0.
- Delay register D:
  - Loaded from delay_sel on every ce edge.
  - Values greater than MAX_DELAY are clamped to MAX_DELAY.
  - cur_delay = D.
- Read tap index = (wptr − D) mod MAX_DELAY, computed with explicit wrap, not power-of-two truncation.
- For D≥1 the tap equals the sample written D ce-strobes earlier. D=1 gives the most recent write.
- D=0 is combinational pass-through:
  - odata = idata, ovalid = ivalid, primed = 1.
  - The array is still written.
- Fill counter fill:
  - Increments on each ce edge.
  - Saturates at MAX_DELAY.
  - Is not cleared by delay changes.
- primed = (D==0) | (fill ≥ D). Raising D above fill drops primed until enough further samples are written.
- ovalid = tap valid bit & primed.
- odata = tap data; see Configuration for gating.
- Per-channel data is never mixed. All CH channels share one pointer and one delay.

## Timing
- Reset values, applied asynchronously and immediately:
  - wptr=0, D=0, fill=0, all array entries 0.
  - Outputs: odata=idata (D=0), ovalid=ivalid, primed=1, cur_delay=0.
- Latency from idata to odata is exactly D ce-strobes. Output is combinational from registers; no extra pipeline stage.
- A delay_sel change takes effect after the ce edge that samples it. On that same edge the write uses the old wptr, and the new tap uses the updated wptr and the new D.
- ce=0: no state changes; odata/ovalid remain stable (for D=0 they follow the inputs).
- Wrap-around: wptr=MAX_DELAY-1 followed by ce gives wptr=0. The tap index wraps identically.
- D=MAX_DELAY reads the slot about to be overwritten, i.e. the sample written MAX_DELAY strobes earlier.
- rst asserted mid-stream discards all contents. The first post-reset sample with D≥1 appears D strobes later, with primed low until then.

## Configuration
- Macro DELAY_LINE_PROG_GATE_EN.
- Defined: odata is forced to all zeros whenever ovalid=0, with D≥1. In D=0 mode, odata=0 when ivalid=0.
- Undefined: odata is the raw tap regardless of ovalid; stale or reset-zero contents are visible while not primed.
- ovalid, primed and cur_delay are identical in both builds.

## Test plan
- Reset, delay_sel=5, ce every cycle, idata=0x000001..0x000020 with ivalid=1 → primed rises after the 5th ce edge, and odata after edge k equals input k−4 (first 0x000001 after edge 5).
- delay_sel=0, toggle idata/ivalid with ce=0 and ce=1 → odata/ovalid follow the inputs combinationally, primed=1, cur_delay=0.
- delay_sel=16 for 40 strobes with an incrementing ramp → odata lags by exactly 16 across two wptr wraps; no glitch at wptr 15→0.
- Running at delay 3 with fill saturated, switch delay_sel to 12 → cur_delay=12 after the next ce, primed stays 1, and odata jumps to the sample from 12 strobes ago. Repeat immediately after reset at fill=4 → primed=0 for 8 more strobes.
- delay_sel=31, exceeding MAX_DELAY → cur_delay=16 and behaviour matches delay 16.
- Assert rst mid-stream at delay 4 with the ce gaps 1-on/1-off pattern → all state clears within the cycle. After release, with GATE_EN, odata=0 and ovalid=0 until 4 ce strobes have elapsed; ce=0 cycles never advance data.
